// File: rtl/waterfall_scroll_ctrl.sv
// Waterfall scroll controller: streams spectrum rows into a circular row buffer
// through a hidden write slot, commits them at frame start, and maps display rows
// to physical buffer rows.
module waterfall_scroll_ctrl #(
    parameter int unsigned NUM_ROWS = 180,
    parameter int unsigned NUM_PHYS = NUM_ROWS + 1,
    parameter int unsigned NUM_BINS = 640,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              vsync,
    input  logic              freeze,
    input  logic              err_clr,
    input  logic [8:0]        disp_row,
    output logic [7:0]        phys_rd_row,
    output logic              wr_en,
    output logic [7:0]        wr_row,
    output logic [9:0]        wr_col,
    output logic [DATA_W-1:0] wr_data,
    output logic              row_commit,
    output logic              err_len
);

    localparam int unsigned ROW_W  = 8;
    localparam int unsigned COL_W  = 10;
    localparam int unsigned DISP_W = 9;
    localparam int unsigned SUM_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2,
        PEND  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ROW_W-1:0]   head;
    logic [ROW_W-1:0]   head_nxt;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   col_nxt;
    logic               vsync_d;

    logic               s_ready_nxt;
    logic               wr_en_nxt;
    logic [ROW_W-1:0]   wr_row_nxt;
    logic [COL_W-1:0]   wr_col_nxt;
    logic [DATA_W-1:0]  wr_data_nxt;
    logic               row_commit_nxt;
    logic               err_set;
    logic [ROW_W-1:0]   phys_rd_row_nxt;

    logic               frame_start_c;
    logic               accept_c;
    logic               col_last_c;
    logic [ROW_W-1:0]   wr_slot_c;
    logic [SUM_W-1:0]   rd_sum_c;

    assign frame_start_c = vsync_d & ~vsync;
    assign accept_c      = s_valid & s_ready;
    assign col_last_c    = (col == COL_W'(NUM_BINS - 1));
    assign wr_slot_c     = (head == '0) ? ROW_W'(NUM_PHYS - 1) : head - ROW_W'(1);
    assign rd_sum_c      = SUM_W'(head) + SUM_W'(disp_row);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, write strobe, commit and ready decode
    always_comb begin
        state_nxt      = state;
        head_nxt       = head;
        col_nxt        = col;
        wr_en_nxt      = 1'b0;
        wr_row_nxt     = wr_row;
        wr_col_nxt     = wr_col;
        wr_data_nxt    = wr_data;
        row_commit_nxt = 1'b0;
        err_set        = 1'b0;
        s_ready_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = s_last ? PEND : WRITE;
                end
            end
            WRITE: begin
                if (accept_c) begin
                    if (s_last) begin
                        state_nxt = PEND;
                        err_set   = ~col_last_c;
                    end else if (col_last_c) begin
                        state_nxt = DRAIN;
                        err_set   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept_c && s_last) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (frame_start_c) begin
                    head_nxt       = wr_slot_c;
                    row_commit_nxt = 1'b1;
                    col_nxt        = '0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Beats accepted in IDLE or WRITE land in the hidden write slot
        if (accept_c && (state == IDLE || state == WRITE)) begin
            wr_en_nxt   = 1'b1;
            wr_row_nxt  = wr_slot_c;
            wr_col_nxt  = col;
            wr_data_nxt = s_data;
            col_nxt     = col + COL_W'(1);
        end

        // Ready is registered, so it is decoded from the state we are heading into
        case (state_nxt)
            IDLE:    s_ready_nxt = ~freeze;
            WRITE:   s_ready_nxt = 1'b1;
            DRAIN:   s_ready_nxt = 1'b1;
            default: s_ready_nxt = 1'b0;
        endcase
    end

    // Display-to-physical row mapping, modulo NUM_PHYS without a divider
    always_comb begin
        phys_rd_row_nxt = '0;
        if (disp_row < DISP_W'(NUM_ROWS)) begin
            if (rd_sum_c >= SUM_W'(NUM_PHYS)) begin
                phys_rd_row_nxt = ROW_W'(rd_sum_c - SUM_W'(NUM_PHYS));
            end else begin
                phys_rd_row_nxt = ROW_W'(rd_sum_c);
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head        <= '0;
            col         <= '0;
            vsync_d     <= 1'b1;
            s_ready     <= 1'b0;
            wr_en       <= 1'b0;
            wr_row      <= '0;
            wr_col      <= '0;
            wr_data     <= '0;
            phys_rd_row <= '0;
            row_commit  <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            head        <= head_nxt;
            col         <= col_nxt;
            vsync_d     <= vsync;
            s_ready     <= s_ready_nxt;
            wr_en       <= wr_en_nxt;
            wr_row      <= wr_row_nxt;
            wr_col      <= wr_col_nxt;
            wr_data     <= wr_data_nxt;
            phys_rd_row <= phys_rd_row_nxt;
            row_commit  <= row_commit_nxt;
            if (err_set) begin
                err_len <= 1'b1;
            end else if (err_clr) begin
                err_len <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_waterfall_scroll_ctrl.sv
// Directed bench for waterfall_scroll_ctrl: row writes, length errors, commit
// timing, freeze, reset abort and head wrap.
module tb_waterfall_scroll_ctrl;

    localparam int NUM_PHYS = 181;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       s_valid  = 1'b0;
    logic [7:0] s_data   = 8'd0;
    logic       s_last   = 1'b0;
    logic       vsync    = 1'b1;
    logic       freeze   = 1'b0;
    logic       err_clr  = 1'b0;
    logic [8:0] disp_row = 9'd0;

    logic       s_ready;
    logic [7:0] phys_rd_row;
    logic       wr_en;
    logic [7:0] wr_row;
    logic [9:0] wr_col;
    logic [7:0] wr_data;
    logic       row_commit;
    logic       err_len;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state, written only by the monitor process
    int         wr_cnt      = 0;
    int         seq_err     = 0;
    int         commit_cnt  = 0;
    logic [9:0] last_col    = 10'd0;
    logic [7:0] last_row    = 8'd0;
    logic       prev_commit = 1'b0;

    waterfall_scroll_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .vsync       (vsync),
        .freeze      (freeze),
        .err_clr     (err_clr),
        .disp_row    (disp_row),
        .phys_rd_row (phys_rd_row),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .row_commit  (row_commit),
        .err_len     (err_len)
    );

    always #5 clk = ~clk;

    // Write and commit monitor: column continuity, data pattern, single-cycle commit
    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_col != 10'd0 && wr_col != last_col + 10'd1) seq_err++;
            if (wr_data != wr_col[7:0]) seq_err++;
            last_col = wr_col;
            last_row = wr_row;
            wr_cnt++;
        end
        if (row_commit) begin
            commit_cnt++;
            if (prev_commit) seq_err++;
        end
        prev_commit = row_commit;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slot(input logic [7:0] h);
        return (h == 8'd0) ? 8'(NUM_PHYS - 1) : h - 8'd1;
    endfunction

    // Sends n beats (data = beat index), optional s_last, vsync low with the final
    // beat, and freeze raised at a given beat; returns cycles spent.
    task automatic send_row(input int n, input int last_at, input bit vs_last,
                            input int frz_at, output int cyc);
        cyc = 0;
        for (int i = 1; i <= n; i++) begin
            logic rdy;
            int   guard;
            s_valid = 1'b1;
            s_data  = 8'(i - 1);
            s_last  = (i == last_at);
            if (vs_last && i == n) vsync = 1'b0;
            if (i == frz_at) freeze = 1'b1;
            guard = 0;
            do begin
                rdy = s_ready;
                tick();
                cyc++;
                guard++;
            end while (!rdy && guard < 100);
            if (!rdy) begin
                check("ready_timeout", 32'(rdy), 32'd1);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        vsync   = 1'b1;
    endtask

    // One vsync falling edge; expects a commit to new_head (disp_row held at 0)
    task automatic do_frame(input logic [7:0] new_head);
        int c0;
        c0    = commit_cnt;
        vsync = 1'b0;
        tick();
        check("commit_pulse", 32'(row_commit), 32'd1);
        vsync = 1'b1;
        tick();
        check("commit_end", 32'(row_commit), 32'd0);
        check("commit_cnt", commit_cnt - c0, 32'd1);
        check("head", 32'(phys_rd_row), 32'(new_head));
    endtask

    initial begin
        int         cyc;
        int         w0;
        int         c0;
        logic [7:0] exp_head;

        // Reset values
        rst_n = 1'b0;
        tick(); tick(); tick();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_row", 32'(wr_row), 32'd0);
        check("rst_wr_col", 32'(wr_col), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_phys", 32'(phys_rd_row), 32'd0);
        check("rst_commit", 32'(row_commit), 32'd0);
        check("rst_err", 32'(err_len), 32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(s_ready), 32'd1);

        // Read mapping with head = 0
        disp_row = 9'd5;   tick(); check("rd_5", 32'(phys_rd_row), 32'd5);
        disp_row = 9'd200; tick(); check("rd_200", 32'(phys_rd_row), 32'd0);
        disp_row = 9'd179; tick(); check("rd_179", 32'(phys_rd_row), 32'd179);
        disp_row = 9'd180; tick(); check("rd_180", 32'(phys_rd_row), 32'd0);
        disp_row = 9'd0;   tick();

        // Full 640-bin row
        w0 = wr_cnt;
        send_row(640, 640, 1'b0, 0, cyc);
        check("full_cycles", cyc, 32'd640);
        tick();
        check("full_writes", wr_cnt - w0, 32'd640);
        check("full_wr_row", 32'(last_row), 32'd180);
        check("full_last_col", 32'(last_col), 32'd639);
        check("full_pend_ready", 32'(s_ready), 32'd0);
        check("full_err", 32'(err_len), 32'd0);
        tick(); tick();
        check("full_no_early_commit", 32'(row_commit), 32'd0);
        do_frame(8'd180);
        disp_row = 9'd1; tick(); check("rd_wrap_1", 32'(phys_rd_row), 32'd0);
        disp_row = 9'd0; tick(); check("rd_wrap_0", 32'(phys_rd_row), 32'd180);

        // 700-beat row: 640 written, 60 drained
        w0 = wr_cnt;
        send_row(700, 700, 1'b0, 0, cyc);
        check("long_cycles", cyc, 32'd700);
        tick();
        check("long_writes", wr_cnt - w0, 32'd640);
        check("long_wr_row", 32'(last_row), 32'd179);
        check("long_err", 32'(err_len), 32'd1);
        do_frame(8'd179);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("long_err_clr", 32'(err_len), 32'd0);

        // 100-beat short row with err_clr held: set wins, then clear
        err_clr = 1'b1;
        w0 = wr_cnt;
        send_row(100, 100, 1'b0, 0, cyc);
        check("short_set_wins", 32'(err_len), 32'd1);
        tick();
        check("short_err_clr", 32'(err_len), 32'd0);
        err_clr = 1'b0;
        check("short_writes", wr_cnt - w0, 32'd100);
        check("short_last_col", 32'(last_col), 32'd99);
        do_frame(8'd178);

        // vsync falling together with the last beat is ignored
        c0 = commit_cnt;
        send_row(640, 640, 1'b1, 0, cyc);
        tick(); tick();
        check("late_vs_no_commit", commit_cnt - c0, 32'd0);
        check("late_vs_head", 32'(phys_rd_row), 32'd178);
        do_frame(8'd177);

        // freeze in IDLE
        s_valid = 1'b0; freeze = 1'b1; tick();
        check("frz_ready", 32'(s_ready), 32'd0);
        w0 = wr_cnt;
        s_valid = 1'b1; s_data = 8'd0; s_last = 1'b1;
        tick(); tick(); tick();
        check("frz_no_writes", wr_cnt - w0, 32'd0);
        check("frz_ready_hold", 32'(s_ready), 32'd0);
        s_valid = 1'b0; s_last = 1'b0; freeze = 1'b0;
        tick();
        check("frz_release", 32'(s_ready), 32'd1);

        // freeze raised mid-row: row completes and commits
        w0 = wr_cnt;
        send_row(640, 640, 1'b0, 50, cyc);
        check("frz_mid_cycles", cyc, 32'd640);
        tick();
        check("frz_mid_writes", wr_cnt - w0, 32'd640);
        do_frame(8'd176);
        check("frz_idle_ready", 32'(s_ready), 32'd0);
        freeze = 1'b0; tick();
        check("frz_idle_release", 32'(s_ready), 32'd1);

        // Reset on beat 300 abandons the row
        c0 = commit_cnt;
        w0 = wr_cnt;
        send_row(299, 0, 1'b0, 0, cyc);
        s_valid = 1'b1; s_data = 8'd43; rst_n = 1'b0;
        tick();
        check("rst_mid_wr_en", 32'(wr_en), 32'd0);
        s_valid = 1'b0; rst_n = 1'b1;
        tick(); tick();
        check("rst_mid_writes", wr_cnt - w0, 32'd299);
        vsync = 1'b0; tick(); vsync = 1'b1; tick(); tick();
        check("rst_mid_no_commit", commit_cnt - c0, 32'd0);
        check("rst_mid_head", 32'(phys_rd_row), 32'd0);
        check("rst_mid_ready", 32'(s_ready), 32'd1);

        // 182 single-beat rows: head 180,179,...,0,180; write slot never displayed
        exp_head = 8'd0;
        for (int r = 0; r < 182; r++) begin
            logic [7:0] sl;
            sl = slot(exp_head);
            send_row(1, 1, 1'b0, 0, cyc);
            tick();
            check("wrap_wr_row", 32'(last_row), 32'(sl));
            check("wrap_hidden_top", 32'(phys_rd_row != last_row), 32'd1);
            do_frame(sl);
            exp_head = sl;
            disp_row = 9'd179; tick();
            check("wrap_rd_179", 32'(phys_rd_row), 32'((int'(exp_head) + 179) % NUM_PHYS));
            check("wrap_hidden_bot", 32'(phys_rd_row != last_row), 32'd1);
            disp_row = 9'd0; tick();
        end

        check("wr_seq", seq_err, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
